// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU sequencer: default widths, opcode encodings,
// FSM state type and the multiply cycle count.
// Configuration macro: ALU_SEQ_MUL_EN adds the MUL state to the state type.
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  localparam int W_DEF      = 8;  // register file word width
  localparam int AW_DEF     = 2;  // register file address width (4 entries)
  localparam int MUL_CYCLES = 8;  // one multiplier bit per cycle

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3
`ifdef ALU_SEQ_MUL_EN
    , S_MUL = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// -----------------------------------------------------------------------------
// alu_seq_mul
// Sequential shift-add multiplier, one multiplier bit per cycle.
// The load cycle already accumulates bit 0 of i_b, each step cycle adds the
// next bit, and o_product includes the bit of the current cycle, so the full
// product is visible during the W-th cycle counted from load.
// Built only when ALU_SEQ_MUL_EN is defined.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_load      capture i_a/i_b and accumulate bit 0
//   i_step      accumulate the next multiplier bit
//   i_a, i_b    multiplicand / multiplier
//   o_product   2W-bit product including the current cycle's bit
// -----------------------------------------------------------------------------
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_load,
  input  logic           i_step,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_product
);

  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [2*W-1:0] w_sum;

  assign w_sum     = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_product = w_sum;

  // NOTE: the datapath registers are reset as well so o_product is never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_load) begin
      r_acc    <= i_b[0] ? {{W{1'b0}}, i_a} : '0;
      r_mcand  <= {{(W-1){1'b0}}, i_a, 1'b0};
      r_mplier <= {1'b0, i_b[W-1:1]};
    end else if (i_step) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Multi-cycle ALU sequencer in front of a 4x8 register file with registered
// read ports. One operation per start: read both operands, compute an 8-bit
// result with zero/carry flags, write the result back to rd.
// Configuration macro: ALU_SEQ_MUL_EN
//   defined   -> op 111 runs an 8-cycle shift-add multiply
//   undefined -> op 111 is illegal: done+err two cycles after start, no write
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op, ra/rb/rd request and its operands, sampled while idle
//   busy, done, err     status; done/err are one-cycle pulses
//   result, zero, carry last written result and flags, held
//   DIR_A/DIR_B/DIR_WR  register file read/write addresses
//   EN, DI              register file write enable / write data
//   DOA, DOB            register file registered read data
// -----------------------------------------------------------------------------
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  input  logic [AW-1:0] rd,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  result,
  output logic          zero,
  output logic          carry,
  output logic [AW-1:0] DIR_A,
  output logic [AW-1:0] DIR_B,
  output logic [AW-1:0] DIR_WR,
  output logic          EN,
  output logic [W-1:0]  DI,
  input  logic [W-1:0]  DOA,
  input  logic [W-1:0]  DOB
);

  state_t        r_state;
  logic [2:0]    r_op;
  logic [AW-1:0] r_rd;
  logic          r_carry_pend;  // flag computed with r_di, published at WB
  logic          r_busy, r_done, r_err, r_zero, r_carry, r_en;
  logic [W-1:0]  r_result, r_di;
  logic [AW-1:0] r_dir_a, r_dir_b, r_dir_wr;
  logic [W:0]    w_alu;         // {carry, result}

  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;
  assign result = r_result;
  assign zero   = r_zero;
  assign carry  = r_carry;
  assign DIR_A  = r_dir_a;
  assign DIR_B  = r_dir_b;
  assign DIR_WR = r_dir_wr;
  assign EN     = r_en;
  assign DI     = r_di;

  // Single-cycle operations; the MSB is the carry/borrow flag.
  always_comb begin
    // NOTE: default first so unlisted opcodes cannot infer a latch.
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = {1'b0, DOA} + {1'b0, DOB};
      OP_SUB:  w_alu = {1'b0, DOA} - {1'b0, DOB};  // MSB is the borrow
      OP_AND:  w_alu = {1'b0, DOA & DOB};
      OP_OR:   w_alu = {1'b0, DOA | DOB};
      OP_XOR:  w_alu = {1'b0, DOA ^ DOB};
      OP_SHL:  w_alu = {DOA, 1'b0};
      OP_SHR:  w_alu = {DOA[0], 1'b0, DOA[W-1:1]};
      default: w_alu = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CNT_W = $clog2(MUL_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [2*W-1:0]   w_product;
  logic             w_mul_load, w_mul_step, w_mul_last;

  // First MUL cycle loads (and takes bit 0), the remaining cycles step.
  assign w_mul_load = (r_state == S_MUL) && (r_cnt == '0);
  assign w_mul_step = (r_state == S_MUL) && (r_cnt != '0);
  assign w_mul_last = (r_cnt == CNT_W'(MUL_CYCLES - 1));

  alu_seq_mul #(.W(W)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_mul_load),
    .i_step    (w_mul_step),
    .i_a       (DOA),
    .i_b       (DOB),
    .o_product (w_product)
  );
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_rd         <= '0;
      r_carry_pend <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_carry      <= 1'b0;
      r_dir_a      <= '0;
      r_dir_b      <= '0;
      r_dir_wr     <= '0;
      r_en         <= 1'b0;
      r_di         <= '0;
`ifdef ALU_SEQ_MUL_EN
      r_cnt        <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Read addresses go out now so the register file captures the
            // operands at the end of READ.
            r_op    <= op;
            r_rd    <= rd;
            r_dir_a <= ra;
            r_dir_b <= rb;
            r_busy  <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (r_op == OP_MUL) begin
`ifdef ALU_SEQ_MUL_EN
            r_cnt   <= '0;
            r_state <= S_MUL;
`else
            // No multiplier: abort without write-back, flags untouched.
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_IDLE;
`endif
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_di         <= w_alu[W-1:0];
          r_carry_pend <= w_alu[W];
          r_dir_wr     <= r_rd;
          r_en         <= 1'b1;
          r_state      <= S_WB;
        end
`ifdef ALU_SEQ_MUL_EN
        S_MUL: begin
          if (w_mul_last) begin
            r_di         <= w_product[W-1:0];
            r_carry_pend <= |w_product[2*W-1:W];
            r_dir_wr     <= r_rd;
            r_en         <= 1'b1;
            r_state      <= S_WB;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        S_WB: begin
          r_en     <= 1'b0;
          r_result <= r_di;
          r_zero   <= (r_di == '0);
          r_carry  <= r_carry_pend;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq paired with a behavioural 4x8 register file
// (registered read ports). Expected results come from plain integer arithmetic
// on a bench-side copy of the register file; expected timing comes from the
// operation latency (4 cycles, 11 for MUL, 2 for an illegal MUL).
// Honours ALU_SEQ_MUL_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = '0;
  logic [1:0] ra = '0, rb = '0, rd = '0;
  logic       busy, done, err, zero, carry, EN;
  logic [7:0] result, DI, DOA, DOB;
  logic [1:0] DIR_A, DIR_B, DIR_WR;

  // Register file model plus a preload port used by the bench.
  logic [7:0] rf [4];
  logic [7:0] pl_vals [4];
  logic       pl_en = 1'b0;

  // Bench-side expectations.
  logic [7:0] exp_rf [4];
  logic [7:0] exp_result = '0;
  logic       exp_zero = 1'b0, exp_carry = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    DOA <= rf[DIR_A];
    DOB <= rf[DIR_B];
    if (pl_en) begin
      for (int i = 0; i < 4; i++) rf[i] <= pl_vals[i];
    end else if (EN) begin
      rf[DIR_WR] <= DI;
    end
  end

  alu_seq #(.W(8), .AW(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .ra     (ra),
    .rb     (rb),
    .rd     (rd),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result),
    .zero   (zero),
    .carry  (carry),
    .DIR_A  (DIR_A),
    .DIR_B  (DIR_B),
    .DIR_WR (DIR_WR),
    .EN     (EN),
    .DI     (DI),
    .DOA    (DOA),
    .DOB    (DOB)
  );

  // Arithmetic meaning of each opcode.
  function automatic void model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] res, output logic c, output logic ill);
    int ai = int'(a);
    int bi = int'(b);
    int r  = 0;
    ill = 1'b0;
    c   = 1'b0;
    case (o)
      3'd0: begin r = ai + bi; c = (r > 255); end
      3'd1: begin r = ai - bi; c = (ai < bi); end
      3'd2: r = ai & bi;
      3'd3: r = ai | bi;
      3'd4: r = ai ^ bi;
      3'd5: begin r = ai * 2; c = (ai >= 128); end
      3'd6: begin r = ai / 2; c = (ai % 2 == 1); end
      default: begin
`ifdef ALU_SEQ_MUL_EN
        r = ai * bi;
        c = (r > 255);
`else
        ill = 1'b1;
`endif
      end
    endcase
    res = r[7:0];
  endfunction

  // Loads all four registers at the next rising edge (the start edge).
  task automatic set_regs(input logic [7:0] v0, input logic [7:0] v1,
                          input logic [7:0] v2, input logic [7:0] v3);
    pl_vals[0] = v0; pl_vals[1] = v1; pl_vals[2] = v2; pl_vals[3] = v3;
    for (int i = 0; i < 4; i++) exp_rf[i] = pl_vals[i];
    pl_en = 1'b1;
  endtask

  // Issues one operation and checks every cycle up to and including done.
  // Entered and left at a falling edge; with hold=1 start stays high.
  task automatic run_op(input logic [2:0] o, input logic [1:0] a_i, input logic [1:0] b_i,
                        input logic [1:0] d_i, input bit hold, input string name);
    logic [7:0] res;
    logic       c, ill;
    logic [3:0] exp_st, got_st;
    int         lat;
    model(o, exp_rf[a_i], exp_rf[b_i], res, c, ill);
    lat = ill ? 2 : ((o == 3'd7) ? 11 : 4);
    op = o; ra = a_i; rb = b_i; rd = d_i; start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(negedge clk);
      pl_en = 1'b0;
      if (!hold) start = 1'b0;
      exp_st = {cyc < lat, cyc == lat, ill && (cyc == lat), !ill && (cyc == lat - 1)};
      got_st = {busy, done, err, EN};
      n_cmp++;
      if (got_st !== exp_st) begin
        n_bad++;
        $display("FAIL %s status cycle %0d: got busy/done/err/EN=%b want %b", name, cyc, got_st, exp_st);
      end
      if (cyc == 1) begin
        n_cmp++;
        if ({DIR_A, DIR_B} !== {a_i, b_i}) begin
          n_bad++;
          $display("FAIL %s read addr: got %0d/%0d want %0d/%0d", name, DIR_A, DIR_B, a_i, b_i);
        end
      end
      if (!ill && cyc == lat - 1) begin
        n_cmp++;
        if ({DIR_WR, DI} !== {d_i, res}) begin
          n_bad++;
          $display("FAIL %s write: got DIR_WR=%0d DI=%h want %0d/%h", name, DIR_WR, DI, d_i, res);
        end
      end
      if (cyc == lat) begin
        if (!ill) begin
          exp_result = res;
          exp_zero   = (res == 8'h00);
          exp_carry  = c;
          exp_rf[d_i] = res;
        end
        n_cmp++;
        if ({result, zero, carry} !== {exp_result, exp_zero, exp_carry}) begin
          n_bad++;
          $display("FAIL %s result/flags: got %h z%b c%b want %h z%b c%b",
                   name, result, zero, carry, exp_result, exp_zero, exp_carry);
        end
        n_cmp++;
        if (rf[d_i] !== exp_rf[d_i]) begin
          n_bad++;
          $display("FAIL %s reg x%0d: got %h want %h", name, d_i, rf[d_i], exp_rf[d_i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, err, EN, zero, carry, result, DI, DIR_A, DIR_B, DIR_WR} !== 30'd0) begin
      n_bad++;
      $display("FAIL reset outputs: got busy%b done%b err%b EN%b z%b c%b res=%h DI=%h dirs=%0d/%0d/%0d want all 0",
               busy, done, err, EN, zero, carry, result, DI, DIR_A, DIR_B, DIR_WR);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, err, EN} !== 4'b0000) begin
      n_bad++;
      $display("FAIL idle after reset: got busy/done/err/EN=%b want 0000", {busy, done, err, EN});
    end
  endtask

  task automatic test_add_overflow();
    set_regs(8'h00, 8'h7F, 8'h81, 8'h55);
    run_op(3'd0, 2'd1, 2'd2, 2'd3, 1'b0, "add_overflow");
  endtask

  task automatic test_sub_borrow();
    set_regs(8'h05, 8'h07, 8'hAA, 8'h00);
    run_op(3'd1, 2'd0, 2'd1, 2'd2, 1'b0, "sub_borrow");
  endtask

  task automatic test_logic_shift();
    set_regs(8'hC3, 8'h81, 8'h0F, 8'hF0);
    run_op(3'd2, 2'd2, 2'd3, 2'd0, 1'b0, "and_zero");
    run_op(3'd3, 2'd2, 2'd3, 2'd1, 1'b0, "or");
    run_op(3'd4, 2'd1, 2'd1, 2'd2, 1'b0, "xor_self");
    set_regs(8'hC3, 8'h81, 8'h0F, 8'hF0);
    run_op(3'd5, 2'd1, 2'd0, 2'd1, 1'b0, "shl_rd_eq_ra");
    run_op(3'd6, 2'd0, 2'd0, 2'd3, 1'b0, "shr");
  endtask

  task automatic test_mul();
`ifdef ALU_SEQ_MUL_EN
    set_regs(8'h0D, 8'h0B, 8'h00, 8'h00);
    run_op(3'd7, 2'd0, 2'd1, 2'd2, 1'b0, "mul_small");
    set_regs(8'h20, 8'h10, 8'hFF, 8'hFF);
    run_op(3'd7, 2'd0, 2'd1, 2'd3, 1'b0, "mul_overflow");
`else
    set_regs(8'h0D, 8'h0B, 8'h66, 8'h00);
    run_op(3'd7, 2'd0, 2'd1, 2'd2, 1'b0, "mul_illegal");
`endif
  endtask

  task automatic test_back_to_back();
    set_regs(8'h11, 8'h22, 8'h33, 8'h44);
    run_op(3'd0, 2'd0, 2'd1, 2'd2, 1'b1, "hold_start");
    run_op(3'd4, 2'd2, 2'd3, 2'd0, 1'b0, "done_cycle_start");
  endtask

  task automatic test_reset_in_wb();
    set_regs(8'h11, 8'h22, 8'h33, 8'h44);
    op = 3'd0; ra = 2'd0; rb = 2'd1; rd = 2'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pl_en = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (EN !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_wb pre: got EN=%b want 1", EN);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({EN, busy, done} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_wb async: got EN/busy/done=%b want 000", {EN, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_result = '0; exp_zero = 1'b0; exp_carry = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, EN} !== 3'b000) begin
        n_bad++;
        $display("FAIL reset_wb after %0d: got busy/done/EN=%b want 000", i, {busy, done, EN});
      end
    end
    n_cmp++;
    if ({rf[2], result} !== {exp_rf[2], exp_result}) begin
      n_bad++;
      $display("FAIL reset_wb state: got x2=%h result=%h want %h/%h", rf[2], result, exp_rf[2], exp_result);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 2) == 0)
        set_regs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      run_op(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 2'($urandom), 1'b0, "random");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) exp_rf[i] = '0;
    test_reset();
    test_add_overflow();
    test_sub_borrow();
    test_logic_shift();
    test_mul();
    test_back_to_back();
    test_reset_in_wb();
    test_random();
    test_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle ALU sequencer that sits between the control path and the 4×8 register file.
- Accepts one operation per start handshake: opcode plus source and destination register addresses.
- Reads both operands from the register file, computes an 8-bit result with zero/carry flags, and writes the result back.
- Drives the register file's read/write address and enable inputs, consumes its registered DOA/DOB outputs, and is its sole writer.

## Interface
Parameters:
- W, 8, data width (register file word width)
- AW, 2, register address width (4 registers)

Ports:
- clk  in  1  rising-edge clock, shared with the register file
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only while busy=0
- op  in  3  opcode, captured with start
- ra  in  AW  source A register, captured with start
- rb  in  AW  source B register, captured with start
- rd  in  AW  destination register, captured with start
- busy  out  1  high from the cycle after start is accepted through write-back
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse coincident with done on an illegal opcode
- result  out  W  last written result, held
- zero  out  1  result==0, held
- carry  out  1  carry/borrow flag, held
- DIR_A  out  AW  register file read address A
- DIR_B  out  AW  register file read address B
- DIR_WR  out  AW  register file write address
- EN  out  1  register file write enable (1=write, 0=read)
- DI  out  W  register file write data
- DOA  in  W  register file output A (registered in the register file)
- DOB  in  W  register file output B (registered in the register file)

## Operation
FSM states: IDLE, READ, EXEC, MUL, WB.
- IDLE: EN=0; DIR_* hold. start=1 latches op/ra/rb/rd and goes to READ.
- READ: DIR_A=ra, DIR_B=rb, EN=0. The register file captures DOA/DOB at the closing edge. Next state is MUL for op 111, else EXEC.
- EXEC: compute from DOA/DOB, register the result, go to WB.
- MUL: shift-add multiply, one bit per cycle, 8 cycles, then WB.
- WB: EN=1, DIR_WR=rd, DI=result for exactly one cycle. Update flags. Return to IDLE and pulse done in the next cycle.

Opcodes; all results are the low W bits:
- 000 ADD: carry = bit 8.
- 001 SUB (A−B): carry = borrow (A<B).
- 010 AND, 011 OR, 100 XOR: carry = 0.
- 101 SHL A by 1: carry = A[7].
- 110 SHR A by 1: carry = A[0].
- 111 MUL: low byte of A×B; carry = 1 if the high byte is nonzero.

Rules:
- zero = (result==0).
- start while busy=1 is ignored.
- EN is 1 only in WB.
- rd may equal ra or rb. The operands are already captured before the write, so this needs no special handling.

## Timing
- Reset (asynchronous, immediate): state=IDLE; busy, done, err, EN, zero, carry = 0; result, DI = 0; DIR_A, DIR_B, DIR_WR = 0.
- Reset mid-operation: EN drops immediately, no write occurs, no done pulse.
- Start accepted at edge 0. Non-MUL ops:
  - READ = cycle 1, EXEC = cycle 2, WB = cycle 3; the register is written at the end of cycle 3.
  - done = 1 and busy = 0 in cycle 4.
- MUL ops: READ = cycle 1, MUL = cycles 2–9, WB = cycle 10, done in cycle 11.
- A start presented in the done cycle is accepted (back-to-back allowed).

## Configuration
Macro: ALU_SEQ_MUL_EN.
- Defined: op 111 executes through MUL as specified.
- Undefined: the MUL state and the multiplier are not built. Op 111 goes READ→IDLE with no WB and no EN pulse; done=1 and err=1 in cycle 2; result and flags are unchanged.

## Structure
- Package alu_seq_pkg holds:
  - opcode localparams (OP_ADD..OP_MUL)
  - state enum
  - W/AW defaults
  - MUL_CYCLES=8
- Sub-module alu_seq_mul: 8-bit sequential shift-add multiplier with load/step/product ports. It is instantiated only under ALU_SEQ_MUL_EN.

## Test plan
The bench pairs the block with a behavioural model of the 4×8 register file.
- ADD overflow: x1=0x7F, x2=0x81, op=000, ra=1, rb=2, rd=3 → cycle 3 EN=1, DIR_WR=3, DI=0x00; cycle 4 done=1, zero=1, carry=1; x3=0x00.
- SUB borrow: x0=0x05, x1=0x07, op=001, rd=2 → x2=0xFE, carry=1, zero=0, done at cycle 4.
- MUL (macro on): 0x0D×0x0B → 0x8F, carry=0, done at cycle 11. Then 0x20×0x10 → 0x00, carry=1, zero=1.
- Handshake: start held high through busy → exactly one operation. A second start in the done cycle completes 4 cycles later.
- Reset in WB: rst_n=0 during cycle 3 → EN=0 immediately, destination register unchanged, busy=0, no done.
- Macro off: op=111 → done=1 and err=1 in cycle 2, EN never 1, result and flags unchanged.
